conv1x1_compute_ctrl: RTL and testbench

Parametrised second-generation controller for the 1×1 convolution datapath. It sequences one feature map row by row: it pulls input pixels from the compute FIFO, drives the weight RAM and the temporary-accumulator RAM addresses, and times the result valid toward the downstream FIFO. Compared with the first generation it adds:
- generic widths and pipeline depths;
- a runtime stride-2 (decimating) mode;
- a `M_Last` end-of-row marker;
- an `Abort` input;
- an internal, registered FIFO-count multiplier.

---
 rtl/tjpu_ctrl_pkg.sv | 21 ++
 rtl/delay_line.sv | 30 +++
 rtl/conv1x1_compute_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_conv1x1_compute_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/tjpu_ctrl_pkg.sv
// rtl/tjpu_ctrl_pkg.sv - shared state encoding and legal-range constants for the 1x1 conv controller
package tjpu_ctrl_pkg;

    // One-hot controller states
    typedef enum logic [6:0] {
        S_IDLE       = 7'b0000001,
        S_WAIT       = 7'b0000010,
        S_JUDGE_FIFO = 7'b0000100,
        S_JUDGE_OUT  = 7'b0001000,
        S_COMPUTE    = 7'b0010000,
        S_SKIP       = 7'b0100000,
        S_JUDGE_ROW  = 7'b1000000
    } state_t;

    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 31;
    localparam int VALID_DELAY_MIN = 1;
    localparam int VALID_DELAY_MAX = 63;
    localparam int WAIT_CNT_W      = 5;

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - fixed-depth register pipeline with synchronous clear; depth 0 is a wire
module delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_pipe
        logic [W-1:0] stages [DEPTH];

        // Shift one stage per cycle; clear empties every stage at once
        always_ff @(posedge clk) begin
            if (clr) begin
                for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
            end else begin
                stages[0] <= d;
                for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
            end
        end

        assign q = stages[DEPTH-1];
    end

endmodule

// File: rtl/conv1x1_compute_ctrl.sv
// rtl/conv1x1_compute_ctrl.sv - row sequencer for the 1x1 convolution datapath
module conv1x1_compute_ctrl
    import tjpu_ctrl_pkg::*;
#(
    parameter int WIDTH_FEATURE_SIZE       = 11,
    parameter int WIDTH_CHANNEL_NUM_REG    = 10,
    parameter int WIDTH_WEIGHT_ADDR        = 9,
    parameter int WIDTH_TEMP_RAM_ADDR_SIZE = 7,
    parameter int WAIT_CYCLES              = 5,
    parameter int ADDR_DELAY               = 2,
    parameter int VALID_DELAY              = 25
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                Start,
    input  logic                                Abort,
    input  logic                                STRIDE2,
    input  logic [WIDTH_FEATURE_SIZE-1:0]       CH_IN_TIMES,
    input  logic [WIDTH_FEATURE_SIZE-1:0]       CH_IN_TIMES_8,
    input  logic [WIDTH_FEATURE_SIZE-1:0]       CH_OUT_TIMES,
    input  logic [WIDTH_FEATURE_SIZE-1:0]       ROW_NUM,
    input  logic                                compute_fifo_ready,
    input  logic                                M_ready,
    output logic                                rd_en_fifo,
    output logic [WIDTH_WEIGHT_ADDR-1:0]        weight_addrb,
    output logic [WIDTH_TEMP_RAM_ADDR_SIZE-1:0] ram_temp_read_address,
    output logic [WIDTH_TEMP_RAM_ADDR_SIZE-1:0] ram_temp_write_address,
    output logic                                M_Valid,
    output logic                                M_Last,
    output logic                                First_Compute_Complete,
    output logic                                Compute_Complete,
    output logic                                Busy,
    output logic [WIDTH_FEATURE_SIZE-1:0]       M_Count_Fifo,
    output logic [WIDTH_FEATURE_SIZE-1:0]       S_Count_Fifo
);

    localparam int WF = WIDTH_FEATURE_SIZE;
    localparam int WC = WIDTH_CHANNEL_NUM_REG;
    localparam int WW = WIDTH_WEIGHT_ADDR;
    localparam int WT = WIDTH_TEMP_RAM_ADDR_SIZE;
    localparam int WAIT_EFF = (WAIT_CYCLES < WAIT_CYCLES_MIN) ? WAIT_CYCLES_MIN :
                              (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
    localparam int VDLY_EFF = (VALID_DELAY < VALID_DELAY_MIN) ? VALID_DELAY_MIN :
                              (VALID_DELAY > VALID_DELAY_MAX) ? VALID_DELAY_MAX : VALID_DELAY;
    localparam logic [WF-1:0] F_ONE = 1;
    localparam logic [WF-1:0] F_TWO = 2;
    localparam logic [WC-1:0] C_ONE = 1;

    state_t                state, state_nxt;
    logic                  stride2_r;
    logic [WF-1:0]         cin_times_r, cout_times_r, row_num_r;
    logic [WC-1:0]         cin, cout;
    logic [WF-1:0]         col, row;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WW-1:0]         weight_r;
    logic [WT-1:0]         rd_addr_r, wr_addr_r;
    logic                  done_r;

    logic cin_last, cout_last, col_last, col_pen, row_last, wait_done;
    logic is_compute, is_skip, last_col, tag, last_tag, first_beat;

    // Channel counters are narrower than the config fields; compare at the config width
    assign cin_last   = ({{(WF-WC){1'b0}}, cin}  + F_ONE) == cin_times_r;
    assign cout_last  = ({{(WF-WC){1'b0}}, cout} + F_ONE) == cout_times_r;
    assign col_last   = (col + F_ONE) == row_num_r;
    assign col_pen    = (col + F_TWO) == row_num_r;
    assign row_last   = (row + F_ONE) == row_num_r;
    assign wait_done  = wait_cnt == WAIT_CNT_W'(WAIT_EFF - 1);
    assign is_compute = state == S_COMPUTE;
    assign is_skip    = state == S_SKIP;

    // In stride-2 mode with an even row width the last kept column is the penultimate one
    assign last_col   = (stride2_r && !row_num_r[0]) ? col_pen : col_last;
    assign tag        = is_compute && cin_last && !(stride2_r && col[0]);
    assign last_tag   = tag && cout_last && last_col;
    assign first_beat = is_compute && (cin == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; Abort overrides everything
    always_comb begin
        state_nxt = state;
        if (Abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (Start) state_nxt = S_WAIT;
                S_WAIT:       if (wait_done) state_nxt = S_JUDGE_FIFO;
                S_JUDGE_FIFO: if (compute_fifo_ready) state_nxt = S_JUDGE_OUT;
                S_JUDGE_OUT: begin
                    if (stride2_r && row[0]) state_nxt = S_SKIP;
                    else if (M_ready)        state_nxt = S_COMPUTE;
                end
                S_COMPUTE:    if (col_last && cout_last && cin_last) state_nxt = S_JUDGE_ROW;
                S_SKIP:       if (col_last && cin_last) state_nxt = S_JUDGE_ROW;
                S_JUDGE_ROW:  state_nxt = row_last ? S_IDLE : S_JUDGE_FIFO;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    // Capture configuration at Start so it is stable for the whole frame
    always_ff @(posedge clk) begin
        if (rst) begin
            stride2_r    <= 1'b0;
            cin_times_r  <= '0;
            cout_times_r <= '0;
            row_num_r    <= '0;
        end else if (state == S_IDLE && Start) begin
            stride2_r    <= STRIDE2;
            cin_times_r  <= CH_IN_TIMES;
            cout_times_r <= CH_OUT_TIMES;
            row_num_r    <= ROW_NUM;
        end
    end

    // Settle counter, re-armed by every accepted Start
    always_ff @(posedge clk) begin
        if (rst || Abort || (state == S_IDLE && Start)) wait_cnt <= '0;
        else if (state == S_WAIT && !wait_done)         wait_cnt <= wait_cnt + 1'b1;
    end

    // Nested cin/cout/col loop for COMPUTE; SKIP reuses cin/col to count pops
    always_ff @(posedge clk) begin
        if (rst || Abort || state == S_IDLE) begin
            cin  <= '0;
            cout <= '0;
            col  <= '0;
            row  <= '0;
        end else begin
            if (is_compute || is_skip) begin
                cin <= cin_last ? '0 : cin + C_ONE;
                if (cin_last) begin
                    if (is_skip) begin
                        col <= col_last ? '0 : col + F_ONE;
                    end else begin
                        cout <= cout_last ? '0 : cout + C_ONE;
                        if (cout_last) col <= col_last ? '0 : col + F_ONE;
                    end
                end
            end
            if (state == S_JUDGE_ROW) row <= row + F_ONE;
        end
    end

    // FIFO pop, RAM address generation and frame-done pulse
    always_ff @(posedge clk) begin
        if (rst || Abort) begin
            rd_en_fifo <= 1'b0;
            weight_r   <= '0;
            rd_addr_r  <= '0;
            wr_addr_r  <= '0;
            done_r     <= 1'b0;
        end else begin
            rd_en_fifo <= (is_compute && cout == '0) || is_skip;
            if (is_compute && cin == '0 && cout == '0) wr_addr_r <= '0;
            else if (rd_en_fifo)                       wr_addr_r <= wr_addr_r + WT'(1);
            else                                       wr_addr_r <= '0;
            if (is_compute) rd_addr_r <= cin_last ? '0 : rd_addr_r + WT'(1);
            else            rd_addr_r <= '0;
            if (is_compute)           weight_r <= (cin_last && cout_last) ? '0 : weight_r + WW'(1);
            else if (state == S_IDLE) weight_r <= '0;
            done_r <= (state == S_JUDGE_ROW) && row_last;
        end
    end

    // Registered words-per-row product, truncated to the field width
    always_ff @(posedge clk) begin
        if (rst) M_Count_Fifo <= '0;
        else     M_Count_Fifo <= ROW_NUM * CH_IN_TIMES_8;
    end

    assign S_Count_Fifo     = {2'b00, M_Count_Fifo[WF-1:2]};
    assign Busy             = state != S_IDLE;
    assign Compute_Complete = done_r;

    delay_line #(.W(2), .DEPTH(VDLY_EFF + 1)) u_valid_dly (
        .clk(clk), .clr(rst || Abort), .d({last_tag, tag}), .q({M_Last, M_Valid})
    );

    delay_line #(.W(1), .DEPTH(VDLY_EFF)) u_first_dly (
        .clk(clk), .clr(rst || Abort), .d(first_beat), .q(First_Compute_Complete)
    );

    delay_line #(.W(WW), .DEPTH(ADDR_DELAY)) u_weight_dly (
        .clk(clk), .clr(rst || Abort), .d(weight_r), .q(weight_addrb)
    );

    delay_line #(.W(2 * WT), .DEPTH(ADDR_DELAY)) u_temp_dly (
        .clk(clk), .clr(rst || Abort), .d({rd_addr_r, wr_addr_r}),
        .q({ram_temp_read_address, ram_temp_write_address})
    );

endmodule

// File: tb/tb_conv1x1_compute_ctrl.sv
// tb/tb_conv1x1_compute_ctrl.sv - directed self-checking bench for conv1x1_compute_ctrl
module tb_conv1x1_compute_ctrl;

    localparam int VD = 3;

    logic        clk = 1'b0;
    logic        rst, Start, Abort, STRIDE2, compute_fifo_ready, M_ready;
    logic [10:0] CH_IN_TIMES, CH_IN_TIMES_8, CH_OUT_TIMES, ROW_NUM;
    logic        rd_en_fifo, M_Valid, M_Last, First_Compute_Complete, Compute_Complete, Busy;
    logic [8:0]  weight_addrb;
    logic [6:0]  ram_temp_read_address, ram_temp_write_address;
    logic [10:0] M_Count_Fifo, S_Count_Fifo;

    always #5 clk = ~clk;

    conv1x1_compute_ctrl #(
        .WIDTH_FEATURE_SIZE(11), .WIDTH_CHANNEL_NUM_REG(10), .WIDTH_WEIGHT_ADDR(9),
        .WIDTH_TEMP_RAM_ADDR_SIZE(7), .WAIT_CYCLES(5), .ADDR_DELAY(2), .VALID_DELAY(VD)
    ) dut (
        .clk(clk), .rst(rst), .Start(Start), .Abort(Abort), .STRIDE2(STRIDE2),
        .CH_IN_TIMES(CH_IN_TIMES), .CH_IN_TIMES_8(CH_IN_TIMES_8), .CH_OUT_TIMES(CH_OUT_TIMES),
        .ROW_NUM(ROW_NUM), .compute_fifo_ready(compute_fifo_ready), .M_ready(M_ready),
        .rd_en_fifo(rd_en_fifo), .weight_addrb(weight_addrb),
        .ram_temp_read_address(ram_temp_read_address), .ram_temp_write_address(ram_temp_write_address),
        .M_Valid(M_Valid), .M_Last(M_Last), .First_Compute_Complete(First_Compute_Complete),
        .Compute_Complete(Compute_Complete), .Busy(Busy),
        .M_Count_Fifo(M_Count_Fifo), .S_Count_Fifo(S_Count_Fifo)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Running event totals sampled on the falling edge
    int cyc = 0, mv_tot = 0, ml_tot = 0, rd_tot = 0, cc_tot = 0, anz_tot = 0;
    int mv_cyc = 0, rd_cyc = 0, fcc_cyc = 0;
    int last_at [128];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (M_Valid) begin
                mv_tot <= mv_tot + 1;
                mv_cyc <= cyc;
            end
            if (M_Valid && M_Last) begin
                ml_tot <= ml_tot + 1;
                last_at[ml_tot % 128] <= mv_tot + 1;
            end
            if (rd_en_fifo) begin
                rd_tot <= rd_tot + 1;
                rd_cyc <= cyc;
            end
            if (First_Compute_Complete) fcc_cyc <= cyc;
            if (Compute_Complete) cc_tot <= cc_tot + 1;
            if (weight_addrb != 0 || ram_temp_read_address != 0 || ram_temp_write_address != 0)
                anz_tot <= anz_tot + 1;
        end
    end

    task automatic start_frame(input int cin, input int cout, input int rows, input logic s2);
        @(posedge clk); #1;
        CH_IN_TIMES  = 11'(cin);
        CH_OUT_TIMES = 11'(cout);
        ROW_NUM      = 11'(rows);
        STRIDE2      = s2;
        Start        = 1'b1;
        @(posedge clk); #1;
        Start        = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (cc_tot == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (VD + 6) @(posedge clk);
        #1;
    endtask

    int mvb, mlb, rdb, ccb, anb, n;

    initial begin
        rst = 1'b1; Start = 1'b0; Abort = 1'b0; STRIDE2 = 1'b0;
        compute_fifo_ready = 1'b1; M_ready = 1'b1;
        CH_IN_TIMES = 11'd1; CH_OUT_TIMES = 11'd1; ROW_NUM = 11'd5; CH_IN_TIMES_8 = 11'd3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", Busy, 0);
        check("rst_rd_en", rd_en_fifo, 0);
        check("rst_valid", {M_Valid, M_Last}, 0);
        check("rst_done", {Compute_Complete, First_Compute_Complete}, 0);
        check("rst_m_count", M_Count_Fifo, 0);
        check("rst_addr", {weight_addrb, ram_temp_read_address, ram_temp_write_address}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("m_count_5x3", M_Count_Fifo, 15);
        check("s_count_5x3", S_Count_Fifo, 3);
        ROW_NUM = 11'd100; CH_IN_TIMES_8 = 11'd30;
        @(posedge clk); #1;
        check("m_count_trunc", M_Count_Fifo, 952);
        check("s_count_trunc", S_Count_Fifo, 238);

        // Full frame, no stride, with a Start pulse mid-frame that must be ignored
        mvb = mv_tot; mlb = ml_tot; rdb = rd_tot; ccb = cc_tot;
        start_frame(2, 2, 4, 1'b0);
        repeat (30) @(posedge clk);
        #1 Start = 1'b1;
        @(posedge clk); #1 Start = 1'b0;
        wait_done(ccb, 2000);
        check("a_done", cc_tot - ccb, 1);
        check("a_valid", mv_tot - mvb, 32);
        check("a_last", ml_tot - mlb, 4);
        check("a_rd_en", rd_tot - rdb, 32);
        for (int k = 0; k < 4; k++) check("a_last_pos", last_at[(mlb + k) % 128] - mvb, 8 * (k + 1));
        check("a_idle", Busy, 0);

        // Stride-2: odd rows drained through SKIP, odd columns untagged
        mvb = mv_tot; mlb = ml_tot; rdb = rd_tot; ccb = cc_tot;
        start_frame(1, 1, 4, 1'b1);
        wait_done(ccb, 2000);
        check("s2_done", cc_tot - ccb, 1);
        check("s2_valid", mv_tot - mvb, 4);
        check("s2_last", ml_tot - mlb, 2);
        check("s2_rd_en", rd_tot - rdb, 16);
        check("s2_last_pos0", last_at[mlb % 128] - mvb, 2);
        check("s2_last_pos1", last_at[(mlb + 1) % 128] - mvb, 4);

        // Downstream not ready: parked in JUDGE_OUT with no pops or address motion
        M_ready = 1'b0;
        mvb = mv_tot; rdb = rd_tot; ccb = cc_tot; anb = anz_tot;
        start_frame(2, 2, 2, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        check("hold_rd_en", rd_tot - rdb, 0);
        check("hold_addr", anz_tot - anb, 0);
        check("hold_valid", mv_tot - mvb, 0);
        check("hold_busy", Busy, 1);
        M_ready = 1'b1;
        wait_done(ccb, 2000);
        check("hold_done", cc_tot - ccb, 1);
        check("hold_rd_after", rd_tot - rdb, 8);
        check("hold_valid_after", mv_tot - mvb, 8);
        check("hold_addr_moved", (anz_tot - anb) > 0, 1);

        // Abort in the middle of row 2, then a clean restart
        rdb = rd_tot; ccb = cc_tot;
        start_frame(2, 2, 4, 1'b0);
        n = 0;
        while (rd_tot - rdb < 20 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("abort_reached", rd_tot - rdb >= 20, 1);
        #1 Abort = 1'b1;
        @(posedge clk); #1 Abort = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_rd_en", rd_en_fifo, 0);
        mvb = mv_tot;
        repeat (VD + 2) @(posedge clk);
        #1;
        check("abort_no_valid", mv_tot - mvb, 0);
        check("abort_no_done", cc_tot - ccb, 0);
        mvb = mv_tot; rdb = rd_tot; ccb = cc_tot;
        start_frame(2, 2, 4, 1'b0);
        wait_done(ccb, 2000);
        check("restart_done", cc_tot - ccb, 1);
        check("restart_valid", mv_tot - mvb, 32);
        check("restart_rd_en", rd_tot - rdb, 32);

        // Single pixel: latency from the lone COMPUTE cycle (one before its pop)
        mvb = mv_tot; mlb = ml_tot; ccb = cc_tot;
        start_frame(1, 1, 1, 1'b0);
        wait_done(ccb, 2000);
        check("one_done", cc_tot - ccb, 1);
        check("one_valid", mv_tot - mvb, 1);
        check("one_last", ml_tot - mlb, 1);
        check("one_valid_lat", mv_cyc - rd_cyc, VD);
        check("one_first_lat", fcc_cyc - rd_cyc, VD - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
